// File: rtl/platform_utils_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : platform_utils_fifo_pkg
//  Purpose  : Shared types and helpers for the platform shim FIFOs.
//             t_fifo_rd_mode selects normal (registered) or show-ahead read;
//             fifo_cnt_width() gives the occupancy counter width for a given
//             address radix (one extra bit so DEPTH itself is representable).
//  Revision : 1.0 - initial release
// ============================================================================
package platform_utils_fifo_pkg;

  typedef enum logic {
    FIFO_RD_NORMAL    = 1'b0,
    FIFO_RD_SHOWAHEAD = 1'b1
  } t_fifo_rd_mode;

  function automatic int fifo_cnt_width(input int radix);
    return radix + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/platform_utils_sc_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : platform_utils_sc_fifo_ram
//  Purpose  : Simple dual-port storage for the single-clock FIFO.
//             One write port, one read port with a registered output that
//             only updates when rd_en is high (so the output holds its value
//             between reads). Contents are never reset.
//  Ports    : clk            - clock
//             wr_en/wr_addr/wr_data - write port
//             rd_en/rd_addr  - read request, data on rd_data next cycle
//             rd_data        - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module platform_utils_sc_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int c_words = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_words];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/platform_utils_sc_fifo_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : platform_utils_sc_fifo_ctl
//  Purpose  : Single-clock parametrised FIFO with selectable normal or
//             show-ahead read, registered almost-full/almost-empty flags and
//             sticky overflow/underflow error flags with clear.
//  Ports    : clk, aclr (async, active-high)
//             data/wrreq     - write side
//             rdreq          - read request (head pop in show-ahead mode)
//             err_clr        - clears sticky overflow/underflow
//             q              - read data
//             empty/full/almfull/almempty/usedw - status, all registered
//             overflow/underflow - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module platform_utils_sc_fifo_ctl
  import platform_utils_fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int DEPTH_RADIX            = 9,
  parameter int SHOWAHEAD              = 0,
  parameter int ALMOST_FULL_THRESHOLD  = 16,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almfull,
  output logic                  almempty,
  output logic [DEPTH_RADIX:0]  usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            c_depth   = 2 ** DEPTH_RADIX;
  localparam int            c_cnt_w   = fifo_cnt_width(DEPTH_RADIX);
  localparam t_fifo_rd_mode c_rd_mode = (SHOWAHEAD != 0) ? FIFO_RD_SHOWAHEAD : FIFO_RD_NORMAL;

  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_two   = c_cnt_w'(2);
  localparam logic [c_cnt_w-1:0] c_cnt_three = c_cnt_w'(3);
  localparam logic [c_cnt_w-1:0] c_cnt_depth = c_cnt_w'(c_depth);
  localparam logic [c_cnt_w-1:0] c_af_level  = c_cnt_w'(c_depth - ALMOST_FULL_THRESHOLD);
  localparam logic [c_cnt_w-1:0] c_ae_level  = c_cnt_w'(ALMOST_EMPTY_THRESHOLD);

  // Threshold sanity checks, evaluated at elaboration.
  if (ALMOST_FULL_THRESHOLD >= c_depth) begin : g_chk_af_thr
    $error("ALMOST_FULL_THRESHOLD must be smaller than the FIFO depth");
  end
  if (ALMOST_EMPTY_THRESHOLD >= c_depth) begin : g_chk_ae_thr
    $error("ALMOST_EMPTY_THRESHOLD must be smaller than the FIFO depth");
  end

  logic [DEPTH_RADIX-1:0] r_wr_ptr;
  logic [DEPTH_RADIX-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]     r_usedw;
  logic [c_cnt_w-1:0]     w_usedw_nxt;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_almfull;
  logic                   r_almempty;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ram_rd_en;
  logic [DEPTH_RADIX-1:0] w_ram_rd_addr;
  logic [DATA_WIDTH-1:0]  w_ram_q;
  logic [DATA_WIDTH-1:0]  w_q;

  // Acceptance uses this cycle's registered flags only: a concurrent read
  // does not make room for a write into a full FIFO, and a write into an
  // empty FIFO cannot be read in the same cycle.
  assign w_push = wrreq && !r_full;
  assign w_pop  = rdreq && !r_empty;

  always_comb begin
    w_usedw_nxt = r_usedw;
    if (w_push && !w_pop) begin
      w_usedw_nxt = r_usedw + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_usedw_nxt = r_usedw - c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_usedw     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_almfull   <= 1'b0;
      r_almempty  <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_usedw    <= w_usedw_nxt;
      // Flags come from next-state occupancy so they line up with usedw.
      r_empty    <= (w_usedw_nxt == '0);
      r_full     <= (w_usedw_nxt == c_cnt_depth);
      r_almfull  <= (w_usedw_nxt >= c_af_level);
      r_almempty <= (w_usedw_nxt <= c_ae_level);
      // A fresh error wins over a clear in the same cycle.
      if (wrreq && r_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rdreq && r_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  platform_utils_sc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_RADIX)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (data),
    .rd_en   (w_ram_rd_en),
    .rd_addr (w_ram_rd_addr),
    .rd_data (w_ram_q)
  );

  if (c_rd_mode == FIFO_RD_SHOWAHEAD) begin : g_showahead
    // Head entry lives in r_out, the second entry in the prefetch slot, the
    // rest in RAM only. r_rd_ptr addresses the head, so the third entry is at
    // r_rd_ptr+2. Every write also lands in RAM; a write that must become the
    // head or second entry next cycle is bypassed straight into the stage
    // because the RAM read could not return it in time.
    localparam logic [DEPTH_RADIX-1:0] c_ptr_two = DEPTH_RADIX'(2);

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_pf_byp;
    logic                  r_pf_sel;   // 1: prefetch entry is the RAM read register
    logic [DATA_WIDTH-1:0] w_pf_data;
    logic                  w_u_eq1;
    logic                  w_u_eq2;
    logic                  w_u_ge2;
    logic                  w_u_ge3;

    assign w_u_eq1   = (r_usedw == c_cnt_one);
    assign w_u_eq2   = (r_usedw == c_cnt_two);
    assign w_u_ge2   = (r_usedw >= c_cnt_two);
    assign w_u_ge3   = (r_usedw >= c_cnt_three);
    assign w_pf_data = r_pf_sel ? w_ram_q : r_pf_byp;

    // RAM read register is only touched when the prefetch slot is refilled,
    // so it stays stable while it holds the prefetch entry.
    assign w_ram_rd_en   = w_pop && w_u_ge3;
    assign w_ram_rd_addr = r_rd_ptr + c_ptr_two;

    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        r_out    <= '0;
        r_pf_byp <= '0;
        r_pf_sel <= 1'b0;
      end else if (w_pop) begin
        if (w_u_ge2) begin
          r_out <= w_pf_data;
        end else if (w_push) begin
          r_out <= data;
        end
        if (w_u_ge3) begin
          r_pf_sel <= 1'b1;
        end else if (w_u_eq2 && w_push) begin
          r_pf_byp <= data;
          r_pf_sel <= 1'b0;
        end
      end else if (w_push) begin
        if (r_empty) begin
          r_out <= data;
        end
        if (w_u_eq1) begin
          r_pf_byp <= data;
          r_pf_sel <= 1'b0;
        end
      end
    end

    assign w_q = r_out;
  end else begin : g_normal
    // RAM output register is q; it is not reset, so mask it until the first
    // read after reset has landed.
    logic r_q_valid;

    assign w_ram_rd_en   = w_pop;
    assign w_ram_rd_addr = r_rd_ptr;

    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        r_q_valid <= 1'b0;
      end else if (w_pop) begin
        r_q_valid <= 1'b1;
      end
    end

    assign w_q = r_q_valid ? w_ram_q : '0;
  end

  assign q         = w_q;
  assign empty     = r_empty;
  assign full      = r_full;
  assign almfull   = r_almfull;
  assign almempty  = r_almempty;
  assign usedw     = r_usedw;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_platform_utils_sc_fifo_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_platform_utils_sc_fifo_ctl
//  Purpose  : Self-checking bench. Two instances (normal and show-ahead read)
//             share one stimulus stream and one queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_platform_utils_sc_fifo_ctl;

  localparam int DW     = 8;
  localparam int RADIX  = 4;
  localparam int DEPTH  = 16;
  localparam int AF_THR = 4;
  localparam int AE_THR = 2;

  logic          clk = 1'b0;
  logic          aclr;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;
  logic          err_clr;

  // index 0: normal read, index 1: show-ahead
  logic [DW-1:0] q        [2];
  logic [RADIX:0] usedw   [2];
  logic          empty    [2];
  logic          full     [2];
  logic          almfull  [2];
  logic          almempty [2];
  logic          overflow [2];
  logic          underflow[2];

  // reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_qn;
  logic          m_ovf;
  logic          m_unf;

  int    n_vec = 0;
  int    n_err = 0;
  string tname = "none";

  always #5 clk = ~clk;

  platform_utils_sc_fifo_ctl #(
    .DATA_WIDTH(DW), .DEPTH_RADIX(RADIX), .SHOWAHEAD(0),
    .ALMOST_FULL_THRESHOLD(AF_THR), .ALMOST_EMPTY_THRESHOLD(AE_THR)
  ) u_dut_n (
    .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .err_clr(err_clr),
    .q(q[0]), .empty(empty[0]), .full(full[0]), .almfull(almfull[0]), .almempty(almempty[0]),
    .usedw(usedw[0]), .overflow(overflow[0]), .underflow(underflow[0])
  );

  platform_utils_sc_fifo_ctl #(
    .DATA_WIDTH(DW), .DEPTH_RADIX(RADIX), .SHOWAHEAD(1),
    .ALMOST_FULL_THRESHOLD(AF_THR), .ALMOST_EMPTY_THRESHOLD(AE_THR)
  ) u_dut_s (
    .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .err_clr(err_clr),
    .q(q[1]), .empty(empty[1]), .full(full[1]), .almfull(almfull[1]), .almempty(almempty[1]),
    .usedw(usedw[1]), .overflow(overflow[1]), .underflow(underflow[1])
  );

  // Expected status word {usedw, empty, full, almfull, almempty, overflow, underflow}
  function automatic logic [10:0] exp_status();
    int sz;
    sz = mq.size();
    return {5'(sz), sz == 0, sz == DEPTH, sz >= DEPTH - AF_THR, sz <= AE_THR, m_ovf, m_unf};
  endfunction

  function automatic logic [10:0] got_status(input int k);
    return {usedw[k], empty[k], full[k], almfull[k], almempty[k], overflow[k], underflow[k]};
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_qn  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  // One clock of stimulus: update the model by the FIFO rules, then compare
  // both instances against it after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic ec);
    int   sz;
    logic acc_w, acc_r;
    wrreq = w; rdreq = r; data = d; err_clr = ec;
    sz    = mq.size();
    acc_w = w && (sz < DEPTH);
    acc_r = r && (sz > 0);
    if (w && !acc_w) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
    if (r && !acc_r) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
    if (acc_r) m_qn = mq.pop_front();
    if (acc_w) mq.push_back(d);
    @(posedge clk); #1;
    wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_status(k) !== exp_status()) begin
        n_err++;
        $display("FAIL %s status dut%0d got %b exp %b", tname, k, got_status(k), exp_status());
      end
    end
    n_vec++;
    if (q[0] !== m_qn) begin
      n_err++;
      $display("FAIL %s q normal got %h exp %h", tname, q[0], m_qn);
    end
    if (mq.size() > 0) begin
      n_vec++;
      if (q[1] !== mq[0]) begin
        n_err++;
        $display("FAIL %s q showahead got %h exp %h", tname, q[1], mq[0]);
      end
    end
  endtask

  task automatic do_reset();
    aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 aclr = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_status(k) !== 11'b00000_1_0_0_1_0_0 || q[k] !== 8'h00) begin
        n_err++;
        $display("FAIL reset dut%0d status %b q %h exp 00000100100 q 00", k, got_status(k), q[k]);
      end
    end
  endtask

  task automatic test_fill_drain();
    tname = "fill_drain";
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (full[k] !== 1'b1 || usedw[k] !== 5'd16) begin
        n_err++;
        $display("FAIL fill dut%0d full %b usedw %0d exp full 1 usedw 16", k, full[k], usedw[k]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_vec++;
      if (q[0] !== 8'(i)) begin
        n_err++;
        $display("FAIL drain q normal got %h exp %h", q[0], 8'(i));
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (empty[k] !== 1'b1) begin
        n_err++;
        $display("FAIL drain dut%0d empty got %b exp 1", k, empty[k]);
      end
    end
  endtask

  task automatic test_thresholds();
    tname = "thresholds";
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (almfull[k] !== (i >= 12) || almempty[k] !== (i <= 2)) begin
          n_err++;
          $display("FAIL thr write%0d dut%0d almfull %b almempty %b exp %b %b",
                   i, k, almfull[k], almempty[k], i >= 12, i <= 2);
        end
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (almempty[k] !== 1'b1 || usedw[k] !== 5'd2) begin
        n_err++;
        $display("FAIL thr read dut%0d almempty %b usedw %0d exp 1 2", k, almempty[k], usedw[k]);
      end
    end
  endtask

  task automatic test_overflow();
    tname = "overflow";
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (overflow[k] !== 1'b1 || usedw[k] !== 5'd16) begin
        n_err++;
        $display("FAIL ovf dut%0d overflow %b usedw %0d exp 1 16", k, overflow[k], usedw[k]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_vec++;
      if (q[0] === 8'hAA) begin
        n_err++;
        $display("FAIL ovf dropped data seen q %h exp not aa", q[0]);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (overflow[k] !== 1'b0) begin
        n_err++;
        $display("FAIL ovf clear dut%0d overflow %b exp 0", k, overflow[k]);
      end
    end
  endtask

  task automatic test_underflow();
    tname = "underflow";
    do_reset();
    step(1'b1, 1'b0, 8'h5C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);     // q normal now 5C, FIFO empty
    step(1'b0, 1'b1, 8'h00, 1'b0);     // rejected read
    n_vec++;
    if (underflow[0] !== 1'b1 || q[0] !== 8'h5C || usedw[0] !== 5'd0) begin
      n_err++;
      $display("FAIL unf flag %b q %h usedw %0d exp 1 5c 0", underflow[0], q[0], usedw[0]);
    end
    step(1'b1, 1'b1, 8'h77, 1'b1);     // clear collides with new error: error wins
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (usedw[k] !== 5'd1 || underflow[k] !== 1'b1) begin
        n_err++;
        $display("FAIL unf wr+rd dut%0d usedw %0d underflow %b exp 1 1", k, usedw[k], underflow[k]);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_steady();
    tname = "steady";
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (usedw[k] !== 5'd8) begin
        n_err++;
        $display("FAIL steady dut%0d usedw %0d exp 8", k, usedw[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    tname = "async_reset";
    do_reset();
    step(1'b0, 1'b1, 8'h00, 1'b0);     // underflow set
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);     // usedw 5, q normal 11, head 12
    #2 aclr = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_status(k) !== 11'b00000_1_0_0_1_0_0 || q[k] !== 8'h00) begin
        n_err++;
        $display("FAIL async dut%0d status %b q %h exp 00000100100 q 00", k, got_status(k), q[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (empty[k] !== 1'b1 || usedw[k] !== 5'd0 || q[k] !== 8'h00) begin
        n_err++;
        $display("FAIL async hold dut%0d empty %b usedw %0d q %h exp 1 0 00", k, empty[k], usedw[k], q[k]);
      end
    end
    aclr = 1'b0;
    step(1'b1, 1'b0, 8'hE1, 1'b0);
    step(1'b1, 1'b1, 8'hE2, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    int pw;
    tname = "random";
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(99) < pw, $urandom_range(99) < 50, 8'($urandom),
             $urandom_range(99) < 10);
      end
    end
  endtask

  initial begin
    aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = '0;
    model_clear();
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    test_underflow();
    test_steady();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
